// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [6:0]  AUX_FUNC_MULDIV = 7'b0000001;
    localparam int unsigned MULDIV_ITER     = 32;
    localparam int unsigned CNT_W           = 5;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit,
// subtract the divisor when it fits and record the quotient bit.
module div_step
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;
    logic            fits;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - (XLEN+2)'(divisor_i);
        fits    = (shifted >= (XLEN+2)'(divisor_i));
        rem_o   = (XLEN+1)'(fits ? diff : shifted);
        quo_o   = {quo_i[XLEN-2:0], fits};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to compute MUL* with a single-cycle 64-bit multiply.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned      PW       = 2 * XLEN;
    localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_ITER - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        func_q, func_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_div_c, signed_a_c, signed_b_c, neg_a_c, neg_b_c;
    logic              div_zero_c, div_ovf_c, direct_c;
    logic [XLEN-1:0]   mag_a_c, mag_b_c;
    logic [PW-1:0]     acc_add_c;
    logic [XLEN:0]     rem_step_c;
    logic [XLEN-1:0]   quo_step_c;

    // Applies the product sign and picks the low or high half.
    function automatic logic [XLEN-1:0] mul_select(input logic [2:0] f, input logic neg,
                                                   input logic [PW-1:0] prod);
        logic [PW-1:0] p;
        p = neg ? -prod : prod;
        return (f == F3_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
    endfunction

    // Operand signedness, magnitudes and early-exit detection on the raw inputs.
    always_comb begin
        is_div_c   = funct3[2];
        signed_a_c = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                     (funct3 == F3_DIV)  || (funct3 == F3_REM);
        signed_b_c = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        neg_a_c    = signed_a_c && opA[XLEN-1];
        neg_b_c    = signed_b_c && opB[XLEN-1];
        mag_a_c    = neg_a_c ? -opA : opA;
        mag_b_c    = neg_b_c ? -opB : opB;
        div_zero_c = is_div_c && (opB == '0);
        div_ovf_c  = is_div_c && !funct3[0] && (opA == SMIN) && (opB == ONES);
`ifdef MULDIV_FAST_MUL_EN
        direct_c   = div_zero_c || div_ovf_c || !is_div_c;
`else
        direct_c   = div_zero_c || div_ovf_c;
`endif
    end

    assign acc_add_c = acc_q + (mplier_q[0] ? mcand_q : '0);

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (rem_step_c),
        .quo_o     (quo_step_c)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = direct_c ? ST_FIN : ST_CALC;
            ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_FIN);
    end

    // Datapath: capture on acceptance, iterate in CALC, load result on the last step.
    always_comb begin
        cnt_d     = cnt_q;
        func_d    = func_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    func_d    = funct3;
                    q_neg_d   = neg_a_c ^ neg_b_c;
                    r_neg_d   = neg_a_c;
                    cnt_d     = '0;
                    acc_d     = '0;
                    mcand_d   = PW'(mag_a_c);
                    mplier_d  = mag_b_c;
                    rem_d     = '0;
                    quo_d     = mag_a_c;
                    divisor_d = mag_b_c;
                    if (div_zero_c)     result_d = funct3[1] ? opA : ONES;
                    else if (div_ovf_c) result_d = funct3[1] ? '0 : SMIN;
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div_c)
                        result_d = mul_select(funct3, neg_a_c ^ neg_b_c,
                                              PW'(mag_a_c) * PW'(mag_b_c));
`endif
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (func_q[2]) begin
                    rem_d = rem_step_c;
                    quo_d = quo_step_c;
                end else begin
                    acc_d    = acc_add_c;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if (cnt_q == CNT_LAST) begin
                    if (!func_q[2])     result_d = mul_select(func_q, q_neg_q, acc_add_c);
                    else if (func_q[1]) result_d = r_neg_q ? -rem_step_c[XLEN-1:0]
                                                           : rem_step_c[XLEN-1:0];
                    else                result_d = q_neg_q ? -quo_step_c : quo_step_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= '0;
            func_q    <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            func_q    <= func_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic RV32M reference.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    muldiv_unit #(.XLEN(32)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .funct3 (funct3),
        .opA    (opA),
        .opB    (opB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        p  = 0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Edges from acceptance until done is visible.
    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2]) begin
            if (b == 32'h0) return 0;
            if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            return 32;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 0;
`else
        return 32;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy_seen);
        @(negedge CLK);
        funct3 = f;
        opA    = a;
        opB    = b;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        busy_seen = busy;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        res   = result;
        start = 1'b0;
        @(posedge CLK);
    endtask

    task automatic test_reset();
        RST    = 1'b1;
        start  = 1'b0;
        funct3 = 3'd0;
        opA    = 32'h0;
        opB    = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
        else n_pass++;
        n_checks++;
        if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_directed();
        vec_t        v[12];
        logic [31:0] res;
        int          lat;
        logic        bz;
        v[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        v[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        v[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        v[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        v[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        v[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        v[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
        v[9]  = '{3'd7, 32'd5,          32'd0,         32'd5};
        v[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        v[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
        for (int i = 0; i < 12; i++) begin
            do_op(v[i].f, v[i].a, v[i].b, res, lat, bz);
            n_checks++;
            if (res !== v[i].exp)
                $display("FAIL directed_result[%0d] f=%0d a=%h b=%h: got %h expected %h",
                         i, v[i].f, v[i].a, v[i].b, res, v[i].exp);
            else n_pass++;
            n_checks++;
            if (lat != ref_latency(v[i].f, v[i].a, v[i].b))
                $display("FAIL directed_latency[%0d]: got %0d expected %0d",
                         i, lat, ref_latency(v[i].f, v[i].a, v[i].b));
            else n_pass++;
            n_checks++;
            if (bz !== 1'b1) $display("FAIL directed_busy[%0d]: got %b expected 1", i, bz);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, res, exp;
        int          lat;
        logic        bz;
        for (int i = 0; i < 60; i++) begin
            f   = 3'($urandom_range(0, 7));
            a   = pick_operand();
            b   = pick_operand();
            exp = ref_result(f, a, b);
            do_op(f, a, b, res, lat, bz);
            n_checks++;
            if (res !== exp)
                $display("FAIL random_result[%0d] f=%0d a=%h b=%h: got %h expected %h",
                         i, f, a, b, res, exp);
            else n_pass++;
            n_checks++;
            if (lat != ref_latency(f, a, b))
                $display("FAIL random_latency[%0d] f=%0d: got %0d expected %0d",
                         i, f, lat, ref_latency(f, a, b));
            else n_pass++;
        end
    endtask

    task automatic test_result_hold();
        logic [31:0] res;
        int          lat;
        logic        bz;
        do_op(3'd5, 32'd1234567, 32'd89, res, lat, bz);
        repeat (4) @(posedge CLK);
        #1;
        n_checks++;
        if (result !== ref_result(3'd5, 32'd1234567, 32'd89))
            $display("FAIL hold_result: got %h expected %h", result,
                     ref_result(3'd5, 32'd1234567, 32'd89));
        else n_pass++;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL hold_idle: got done=%b busy=%b expected done=0 busy=0", done, busy);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge CLK);
        funct3 = 3'd5;
        opA    = 32'd1000;
        opB    = 32'd7;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge CLK);
            #1;
            lat++;
            if (lat == 5) begin
                start  = 1'b0;
                funct3 = 3'd4;
                opA    = 32'd5;
                opB    = 32'd0;
            end
            if (lat == 6) start = 1'b1;
            if (lat == 9) funct3 = 3'd0;
        end
        n_checks++;
        if (result !== ref_result(3'd5, 32'd1000, 32'd7))
            $display("FAIL ignored_start_result: got %h expected %h", result,
                     ref_result(3'd5, 32'd1000, 32'd7));
        else n_pass++;
        n_checks++;
        if (lat != 32) $display("FAIL ignored_start_latency: got %0d expected 32", lat);
        else n_pass++;
        start = 1'b0;
        @(posedge CLK);
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        logic        bz;
        @(negedge CLK);
        funct3 = 3'd5;
        opA    = 32'hDEAD_BEEF;
        opB    = 32'd13;
        start  = 1'b1;
        @(posedge CLK);
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done);
        else n_pass++;
        n_checks++;
        if (result !== 32'h0) $display("FAIL midreset_result: got %h expected 00000000", result);
        else n_pass++;
        start = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        do_op(3'd5, 32'd9, 32'd3, res, lat, bz);
        n_checks++;
        if (res !== 32'd3) $display("FAIL after_reset_divu: got %h expected 00000003", res);
        else n_pass++;
        n_checks++;
        if (lat != 32) $display("FAIL after_reset_latency: got %0d expected 32", lat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_result_hold();
        test_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
